// File: rtl/mt.sv
// Speculative rename map table for a 2-wide rename stage with an
// architectural (retirement) map used to recover from branch mispredicts.
module mt #(
  parameter int unsigned NUM_AR = 32,
  parameter int unsigned PR_W   = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                id_dispatch_num,
  input  logic [$clog2(NUM_AR)-1:0] id_dest0_idx,
  input  logic [$clog2(NUM_AR)-1:0] id_dest1_idx,
  input  logic [$clog2(NUM_AR)-1:0] id_src0a_idx,
  input  logic [$clog2(NUM_AR)-1:0] id_src0b_idx,
  input  logic [$clog2(NUM_AR)-1:0] id_src1a_idx,
  input  logic [$clog2(NUM_AR)-1:0] id_src1b_idx,
  input  logic [PR_W-1:0]           fl_pr0,
  input  logic [PR_W-1:0]           fl_pr1,
  input  logic                      cdb_valid0,
  input  logic                      cdb_valid1,
  input  logic [PR_W-1:0]           cdb_tag0,
  input  logic [PR_W-1:0]           cdb_tag1,
  input  logic [1:0]                rob_retire_num,
  input  logic [$clog2(NUM_AR)-1:0] rob_retire_ar0,
  input  logic [$clog2(NUM_AR)-1:0] rob_retire_ar1,
  input  logic [PR_W-1:0]           rob_retire_pr0,
  input  logic [PR_W-1:0]           rob_retire_pr1,
  input  logic                      rob_mispredict,
  output logic [PR_W-1:0]           mt_rs_src0a_tag,
  output logic [PR_W-1:0]           mt_rs_src0b_tag,
  output logic [PR_W-1:0]           mt_rs_src1a_tag,
  output logic [PR_W-1:0]           mt_rs_src1b_tag,
  output logic                      mt_rs_src0a_rdy,
  output logic                      mt_rs_src0b_rdy,
  output logic                      mt_rs_src1a_rdy,
  output logic                      mt_rs_src1b_rdy,
  output logic [PR_W-1:0]           mt_rob_told0,
  output logic [PR_W-1:0]           mt_rob_told1
);

  localparam int unsigned AR_W = $clog2(NUM_AR);

  logic [PR_W-1:0]   spec_tag     [NUM_AR];
  logic [PR_W-1:0]   spec_tag_nxt [NUM_AR];
  logic [NUM_AR-1:0] spec_rdy;
  logic [NUM_AR-1:0] spec_rdy_nxt;
  logic [PR_W-1:0]   arch_tag     [NUM_AR];
  logic [PR_W-1:0]   arch_nxt     [NUM_AR];

  logic            slot0_act;
  logic            slot1_act;
  logic [AR_W-1:0] src_idx [4];
  logic [PR_W-1:0] src_tag [4];
  logic            src_rdy [4];

  assign slot0_act  = (id_dispatch_num != 2'd0);
  assign slot1_act  = (id_dispatch_num == 2'd2);
  assign src_idx[0] = id_src0a_idx;
  assign src_idx[1] = id_src0b_idx;
  assign src_idx[2] = id_src1a_idx;
  assign src_idx[3] = id_src1b_idx;

  // Source lookup: map read, CDB bypass, then slot-1 dependence on slot 0's dest.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      src_tag[s] = spec_tag[src_idx[s]];
      src_rdy[s] = spec_rdy[src_idx[s]]
                 | (cdb_valid0 && (cdb_tag0 == spec_tag[src_idx[s]]))
                 | (cdb_valid1 && (cdb_tag1 == spec_tag[src_idx[s]]));
      if ((s >= 2) && slot1_act && (src_idx[s] == id_dest0_idx)) begin
        src_tag[s] = fl_pr0;
        src_rdy[s] = 1'b0;
      end
      if ((s < 2) ? !slot0_act : !slot1_act) begin
        src_tag[s] = '0;
        src_rdy[s] = 1'b0;
      end
    end
  end

  assign mt_rs_src0a_tag = src_tag[0];
  assign mt_rs_src0b_tag = src_tag[1];
  assign mt_rs_src1a_tag = src_tag[2];
  assign mt_rs_src1b_tag = src_tag[3];
  assign mt_rs_src0a_rdy = src_rdy[0];
  assign mt_rs_src0b_rdy = src_rdy[1];
  assign mt_rs_src1a_rdy = src_rdy[2];
  assign mt_rs_src1b_rdy = src_rdy[3];

  assign mt_rob_told0 = slot0_act ? spec_tag[id_dest0_idx] : '0;
  assign mt_rob_told1 = !slot1_act                     ? '0 :
                        (id_dest1_idx == id_dest0_idx) ? fl_pr0 :
                                                         spec_tag[id_dest1_idx];

  // Architectural map after this cycle's retirements (slot 1 is younger).
  always_comb begin
    arch_nxt = arch_tag;
    if (rob_retire_num != 2'd0) arch_nxt[rob_retire_ar0] = rob_retire_pr0;
    if (rob_retire_num == 2'd2) arch_nxt[rob_retire_ar1] = rob_retire_pr1;
  end

  // Speculative map next state; a mispredict discards dispatch and CDB updates.
  always_comb begin
    spec_tag_nxt = spec_tag;
    spec_rdy_nxt = spec_rdy;
    if (rob_mispredict) begin
      spec_tag_nxt = arch_nxt;
      spec_rdy_nxt = '1;
    end else begin
      for (int i = 0; i < NUM_AR; i++) begin
        if ((cdb_valid0 && (cdb_tag0 == spec_tag[i])) ||
            (cdb_valid1 && (cdb_tag1 == spec_tag[i])))
          spec_rdy_nxt[i] = 1'b1;
      end
      if (slot0_act) begin
        spec_tag_nxt[id_dest0_idx] = fl_pr0;
        spec_rdy_nxt[id_dest0_idx] = 1'b0;
      end
      if (slot1_act) begin
        spec_tag_nxt[id_dest1_idx] = fl_pr1;
        spec_rdy_nxt[id_dest1_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AR; i++) begin
        spec_tag[i] <= PR_W'(i);
        arch_tag[i] <= PR_W'(i);
      end
      spec_rdy <= '1;
    end else begin
      spec_tag <= spec_tag_nxt;
      spec_rdy <= spec_rdy_nxt;
      arch_tag <= arch_nxt;
    end
  end

endmodule

// File: tb/tb_mt.sv
// Directed and randomized checks of the rename map table against a
// sequential-rename reference model.
module tb_mt;

  localparam int unsigned PR_W = 7;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      id_dispatch_num;
  logic [4:0]      id_dest0_idx, id_dest1_idx;
  logic [4:0]      id_src0a_idx, id_src0b_idx, id_src1a_idx, id_src1b_idx;
  logic [PR_W-1:0] fl_pr0, fl_pr1;
  logic            cdb_valid0, cdb_valid1;
  logic [PR_W-1:0] cdb_tag0, cdb_tag1;
  logic [1:0]      rob_retire_num;
  logic [4:0]      rob_retire_ar0, rob_retire_ar1;
  logic [PR_W-1:0] rob_retire_pr0, rob_retire_pr1;
  logic            rob_mispredict;
  logic [PR_W-1:0] mt_rs_src0a_tag, mt_rs_src0b_tag, mt_rs_src1a_tag, mt_rs_src1b_tag;
  logic            mt_rs_src0a_rdy, mt_rs_src0b_rdy, mt_rs_src1a_rdy, mt_rs_src1b_rdy;
  logic [PR_W-1:0] mt_rob_told0, mt_rob_told1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register -> (tag, ready), plus committed register -> tag.
  int m_tag  [32];
  bit m_rdy  [32];
  int m_arch [32];

  mt dut (
    .clock(clock), .reset(reset),
    .id_dispatch_num(id_dispatch_num),
    .id_dest0_idx(id_dest0_idx), .id_dest1_idx(id_dest1_idx),
    .id_src0a_idx(id_src0a_idx), .id_src0b_idx(id_src0b_idx),
    .id_src1a_idx(id_src1a_idx), .id_src1b_idx(id_src1b_idx),
    .fl_pr0(fl_pr0), .fl_pr1(fl_pr1),
    .cdb_valid0(cdb_valid0), .cdb_valid1(cdb_valid1),
    .cdb_tag0(cdb_tag0), .cdb_tag1(cdb_tag1),
    .rob_retire_num(rob_retire_num),
    .rob_retire_ar0(rob_retire_ar0), .rob_retire_ar1(rob_retire_ar1),
    .rob_retire_pr0(rob_retire_pr0), .rob_retire_pr1(rob_retire_pr1),
    .rob_mispredict(rob_mispredict),
    .mt_rs_src0a_tag(mt_rs_src0a_tag), .mt_rs_src0b_tag(mt_rs_src0b_tag),
    .mt_rs_src1a_tag(mt_rs_src1a_tag), .mt_rs_src1b_tag(mt_rs_src1b_tag),
    .mt_rs_src0a_rdy(mt_rs_src0a_rdy), .mt_rs_src0b_rdy(mt_rs_src0b_rdy),
    .mt_rs_src1a_rdy(mt_rs_src1a_rdy), .mt_rs_src1b_rdy(mt_rs_src1b_rdy),
    .mt_rob_told0(mt_rob_told0), .mt_rob_told1(mt_rob_told1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic bit cdb_hit(input int t);
    return (cdb_valid0 && (int'(cdb_tag0) == t)) || (cdb_valid1 && (int'(cdb_tag1) == t));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_tag[i] = i; m_rdy[i] = 1'b1; m_arch[i] = i;
    end
  endtask

  task automatic clear_inputs();
    id_dispatch_num = 2'd0; id_dest0_idx = 5'd0; id_dest1_idx = 5'd0;
    id_src0a_idx = 5'd0; id_src0b_idx = 5'd0; id_src1a_idx = 5'd0; id_src1b_idx = 5'd0;
    fl_pr0 = '0; fl_pr1 = '0;
    cdb_valid0 = 1'b0; cdb_valid1 = 1'b0; cdb_tag0 = '0; cdb_tag1 = '0;
    rob_retire_num = 2'd0; rob_retire_ar0 = 5'd0; rob_retire_ar1 = 5'd0;
    rob_retire_pr0 = '0; rob_retire_pr1 = '0; rob_mispredict = 1'b0;
  endtask

  // Expected lookups: slot 1 sees the group as if slot 0 had already renamed.
  task automatic settle_and_check();
    int idx [4];
    int et [4];
    bit er [4];
    logic [PR_W-1:0] ot [4];
    logic orr [4];
    int n, et0, et1;
    #1;
    n = int'(id_dispatch_num);
    idx[0] = int'(id_src0a_idx); idx[1] = int'(id_src0b_idx);
    idx[2] = int'(id_src1a_idx); idx[3] = int'(id_src1b_idx);
    ot[0] = mt_rs_src0a_tag; ot[1] = mt_rs_src0b_tag; ot[2] = mt_rs_src1a_tag; ot[3] = mt_rs_src1b_tag;
    orr[0] = mt_rs_src0a_rdy; orr[1] = mt_rs_src0b_rdy; orr[2] = mt_rs_src1a_rdy; orr[3] = mt_rs_src1b_rdy;
    for (int s = 0; s < 4; s++) begin
      if (n <= s / 2) begin
        et[s] = 0; er[s] = 1'b0;
      end else if (s >= 2 && idx[s] == int'(id_dest0_idx)) begin
        et[s] = int'(fl_pr0); er[s] = 1'b0;
      end else begin
        et[s] = m_tag[idx[s]]; er[s] = m_rdy[idx[s]] || cdb_hit(et[s]);
      end
      check($sformatf("src%0d_tag", s), 32'(ot[s]), 32'(et[s]));
      check($sformatf("src%0d_rdy", s), 32'(orr[s]), 32'(er[s]));
    end
    et0 = (n >= 1) ? m_tag[id_dest0_idx] : 0;
    et1 = (n < 2) ? 0 : (id_dest1_idx == id_dest0_idx) ? int'(fl_pr0) : m_tag[id_dest1_idx];
    check("told0", 32'(mt_rob_told0), 32'(et0));
    check("told1", 32'(mt_rob_told1), 32'(et1));
  endtask

  task automatic clock_edge();
    @(posedge clock);
    if (!reset) return;
    if (rob_retire_num >= 2'd1) m_arch[rob_retire_ar0] = int'(rob_retire_pr0);
    if (rob_retire_num == 2'd2) m_arch[rob_retire_ar1] = int'(rob_retire_pr1);
    if (rob_mispredict) begin
      for (int i = 0; i < 32; i++) begin m_tag[i] = m_arch[i]; m_rdy[i] = 1'b1; end
    end else begin
      for (int i = 0; i < 32; i++) if (cdb_hit(m_tag[i])) m_rdy[i] = 1'b1;
      if (id_dispatch_num >= 2'd1) begin m_tag[id_dest0_idx] = int'(fl_pr0); m_rdy[id_dest0_idx] = 1'b0; end
      if (id_dispatch_num == 2'd2) begin m_tag[id_dest1_idx] = int'(fl_pr1); m_rdy[id_dest1_idx] = 1'b0; end
    end
  endtask

  function automatic int restored_tag(input int r);
    return (r == 1) ? 32 : (r == 4) ? 33 : (r == 7) ? 41 : r;
  endfunction

  initial begin
    int r;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Reset identity lookups
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd1; id_dest0_idx = 5'd5; id_src0a_idx = 5'd5; id_src0b_idx = 5'd31; fl_pr0 = 7'd60;
    settle_and_check();
    check("reset_r5_tag", 32'(mt_rs_src0a_tag), 32'd5);
    check("reset_r31_tag", 32'(mt_rs_src0b_tag), 32'd31);
    check("reset_r5_rdy", 32'(mt_rs_src0a_rdy), 32'd1);
    check("reset_told_r5", 32'(mt_rob_told0), 32'd5);
    clock_edge();

    // r1 <- r2+r3 ; r4 <- r1+r1
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd2; id_dest0_idx = 5'd1; id_src0a_idx = 5'd2; id_src0b_idx = 5'd3; fl_pr0 = 7'd32;
    id_dest1_idx = 5'd4; id_src1a_idx = 5'd1; id_src1b_idx = 5'd1; fl_pr1 = 7'd33;
    settle_and_check();
    check("dep_src1a_tag", 32'(mt_rs_src1a_tag), 32'd32);
    check("dep_src1b_rdy", 32'(mt_rs_src1b_rdy), 32'd0);
    check("dep_told1", 32'(mt_rob_told1), 32'd4);
    clock_edge();

    // Same-destination pair on r7, reading r1/r4 renamed last cycle
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd2; id_dest0_idx = 5'd7; id_dest1_idx = 5'd7; fl_pr0 = 7'd40; fl_pr1 = 7'd41;
    id_src0a_idx = 5'd1; id_src0b_idx = 5'd4; id_src1a_idx = 5'd7; id_src1b_idx = 5'd9;
    settle_and_check();
    check("r1_after_dispatch", 32'(mt_rs_src0a_tag), 32'd32);
    check("r1_not_ready", 32'(mt_rs_src0a_rdy), 32'd0);
    check("r4_after_dispatch", 32'(mt_rs_src0b_tag), 32'd33);
    check("samedest_told0", 32'(mt_rob_told0), 32'd7);
    check("samedest_told1", 32'(mt_rob_told1), 32'd40);
    clock_edge();

    // CDB bypass of tag 32
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd1; id_dest0_idx = 5'd10; fl_pr0 = 7'd42; id_src0a_idx = 5'd1; id_src0b_idx = 5'd7;
    cdb_valid0 = 1'b1; cdb_tag0 = 7'd32;
    settle_and_check();
    check("bypass_r1_rdy", 32'(mt_rs_src0a_rdy), 32'd1);
    check("r7_slot1_wins", 32'(mt_rs_src0b_tag), 32'd41);
    clock_edge();

    // CDB 41 racing a remap of r7; retire r1/r4
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd2; id_dest0_idx = 5'd7; fl_pr0 = 7'd43; id_dest1_idx = 5'd8; fl_pr1 = 7'd44;
    id_src0a_idx = 5'd1; id_src0b_idx = 5'd7; id_src1a_idx = 5'd2; id_src1b_idx = 5'd3;
    cdb_valid1 = 1'b1; cdb_tag1 = 7'd41;
    rob_retire_num = 2'd2; rob_retire_ar0 = 5'd1; rob_retire_pr0 = 7'd32;
    rob_retire_ar1 = 5'd4; rob_retire_pr1 = 7'd33;
    settle_and_check();
    check("r1_rdy_held", 32'(mt_rs_src0a_rdy), 32'd1);
    check("bypass_r7_rdy", 32'(mt_rs_src0b_rdy), 32'd1);
    clock_edge();

    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd1; id_dest0_idx = 5'd11; fl_pr0 = 7'd45; id_src0a_idx = 5'd7; id_src0b_idx = 5'd8;
    settle_and_check();
    check("r7_dispatch_over_cdb_tag", 32'(mt_rs_src0a_tag), 32'd43);
    check("r7_dispatch_over_cdb_rdy", 32'(mt_rs_src0a_rdy), 32'd0);
    clock_edge();

    // Mispredict together with retire (r7,41); the dispatch and CDB are dropped
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd2; id_dest0_idx = 5'd1; fl_pr0 = 7'd46; id_dest1_idx = 5'd2; fl_pr1 = 7'd47;
    cdb_valid0 = 1'b1; cdb_tag0 = 7'd43;
    rob_retire_num = 2'd1; rob_retire_ar0 = 5'd7; rob_retire_pr0 = 7'd41;
    rob_mispredict = 1'b1;
    clock_edge();

    // Scan the restored map four registers at a time
    for (int k = 0; k < 8; k++) begin
      @(negedge clock); clear_inputs();
      id_dispatch_num = 2'd2;
      id_src0a_idx = 5'(4*k); id_src0b_idx = 5'(4*k+1);
      id_src1a_idx = 5'(4*k+2); id_src1b_idx = 5'(4*k+3);
      settle_and_check();
      check($sformatf("restore_r%0d", 4*k),   32'(mt_rs_src0a_tag), 32'(restored_tag(4*k)));
      check($sformatf("restore_r%0d", 4*k+1), 32'(mt_rs_src0b_tag), 32'(restored_tag(4*k+1)));
      check($sformatf("restore_r%0d", 4*k+2), 32'(mt_rs_src1a_tag), 32'(restored_tag(4*k+2)));
      check($sformatf("restore_r%0d", 4*k+3), 32'(mt_rs_src1b_tag), 32'(restored_tag(4*k+3)));
      check($sformatf("restore_rdy_r%0d", 4*k+1), 32'(mt_rs_src0b_rdy), 32'd1);
      check($sformatf("restore_rdy_r%0d", 4*k+3), 32'(mt_rs_src1b_rdy), 32'd1);
      clock_edge();
    end

    // Asynchronous reset between edges
    @(negedge clock); clear_inputs();
    id_dispatch_num = 2'd2; id_dest0_idx = 5'd9; id_dest1_idx = 5'd9; fl_pr0 = 7'd70; fl_pr1 = 7'd71;
    id_src0a_idx = 5'd1; id_src0b_idx = 5'd4; id_src1a_idx = 5'd7; id_src1b_idx = 5'd5;
    #2;
    reset = 1'b0;
    model_reset();
    settle_and_check();
    check("async_r1", 32'(mt_rs_src0a_tag), 32'd1);
    check("async_r4", 32'(mt_rs_src0b_tag), 32'd4);
    check("async_r7", 32'(mt_rs_src1a_tag), 32'd7);
    check("async_r5_rdy", 32'(mt_rs_src1b_rdy), 32'd1);
    clock_edge();
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clock); clear_inputs();
      id_dispatch_num = 2'($urandom_range(0, 2));
      id_dest0_idx = 5'($urandom_range(0, 31)); id_dest1_idx = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) id_dest1_idx = id_dest0_idx;
      id_src0a_idx = 5'($urandom_range(0, 31)); id_src0b_idx = 5'($urandom_range(0, 31));
      id_src1a_idx = 5'($urandom_range(0, 31)); id_src1b_idx = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) id_src1a_idx = id_dest0_idx;
      fl_pr0 = 7'($urandom_range(0, 95)); fl_pr1 = 7'($urandom_range(0, 95));
      cdb_valid0 = 1'($urandom_range(0, 1)); cdb_valid1 = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 31));
      cdb_tag0 = ($urandom_range(0, 1) == 0) ? 7'(m_tag[r]) : 7'($urandom_range(0, 95));
      r = int'($urandom_range(0, 31));
      cdb_tag1 = 7'(m_tag[r]);
      rob_retire_num = 2'($urandom_range(0, 2));
      rob_retire_ar0 = 5'($urandom_range(0, 31)); rob_retire_ar1 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rob_retire_ar1 = rob_retire_ar0;
      rob_retire_pr0 = 7'($urandom_range(0, 95)); rob_retire_pr1 = 7'($urandom_range(0, 95));
      rob_mispredict = ($urandom_range(0, 15) == 0);
      if (!rob_mispredict) settle_and_check();
      clock_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
